// File: rtl/sequenciador_pkg.sv
// Shared types for the multi-cycle sequencer: state encodings, PC source selects
// and the latched instruction class computed once in DECODE.
package sequenciador_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Instruction class resolved with hlt > jump > setJump > branch > memW > load priority
  typedef enum logic [2:0] {
    K_NONE   = 3'd0,
    K_HLT    = 3'd1,
    K_JUMP   = 3'd2,
    K_SJMP   = 3'd3,
    K_BRANCH = 3'd4,
    K_STORE  = 3'd5,
    K_LOAD   = 3'd6,
    K_WB     = 3'd7
  } kind_t;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JR  = 2'd2;

  // Lower-priority terms are only consulted when every higher term is 0, so X there is harmless
  function automatic kind_t classify(input logic hlt, input logic jump, input logic set_jump,
                                     input logic branch, input logic mem_w, input logic we_reg,
                                     input logic mem_to_reg);
    kind_t k;
    if (hlt) begin
      k = K_HLT;
    end else if (jump) begin
      k = K_JUMP;
    end else if (set_jump) begin
      k = K_SJMP;
    end else if (branch) begin
      k = K_BRANCH;
    end else if (mem_w) begin
      k = K_STORE;
    end else if (we_reg & mem_to_reg) begin
      k = K_LOAD;
    end else if (we_reg) begin
      k = K_WB;
    end else begin
      k = K_NONE;
    end
    return k;
  endfunction

endpackage

// File: rtl/sequenciador_if.sv
// Control/handshake bundle between the sequencer, the decoder, the ALU flag and memory.
interface sequenciador_if #(parameter int CNT_W = 16);
  logic             branch;
  logic             notEqual;
  logic             jump;
  logic             setJump;
  logic             hlt;
  logic             weReg;
  logic             memW;
  logic             memToReg;
  logic             ula_zero;
  logic             mem_ready;
  logic             resume;
  logic             mem_req;
  logic             mem_sel;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic             sjmp_we;
  logic             mdr_we;
  logic             reg_we;
  logic             halted;
  logic             erro;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  branch, notEqual, jump, setJump, hlt, weReg, memW, memToReg,
    input  ula_zero, mem_ready, resume,
    output mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src, sjmp_we, mdr_we, reg_we,
    output halted, erro, instr_count
  );

  modport slave (
    output branch, notEqual, jump, setJump, hlt, weReg, memW, memToReg,
    output ula_zero, mem_ready, resume,
    input  mem_req, mem_sel, mem_we, ir_we, pc_we, pc_src, sjmp_we, mdr_we, reg_we,
    input  halted, erro, instr_count
  );
endinterface

// File: rtl/sequenciador_cont_espera.sv
// Saturating memory-wait counter; expira flags the cycle whose stall would reach MAX_WAIT.
module cont_espera #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expira
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] LAST  = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] count;

  // Count stalled request cycles, holding at LIMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {WAIT_W{1'b0}};
    end else if (clr) begin
      count <= {WAIT_W{1'b0}};
    end else if (en && (count != LIMIT)) begin
      count <= count + WAIT_W'(1);
    end else begin
      count <= count;
    end
  end

  // A ready in the same cycle disables en, so a last-moment completion still succeeds
  assign expira = en && (count == LAST);

endmodule

// File: rtl/sequenciador.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the shared memory port,
// with halt/resume, sticky memory timeout and a retired-instruction counter.
module sequenciador
  import sequenciador_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  sequenciador_if.master bus
);

  state_t           state_r;
  kind_t            kind_r;
  logic             ne_r;
  logic             erro_r;
  logic             halted_r;
  logic [CNT_W-1:0] count_r;

  kind_t decoded_s;
  logic  mem_phase_s;
  logic  wait_en_s;
  logic  wait_clr_s;
  logic  expira_s;
  logic  taken_s;

  logic       mem_req_s;
  logic       mem_sel_s;
  logic       mem_we_s;
  logic       ir_we_s;
  logic       pc_we_s;
  logic [1:0] pc_src_s;
  logic       sjmp_we_s;
  logic       mdr_we_s;
  logic       reg_we_s;

  assign decoded_s = classify(bus.hlt, bus.jump, bus.setJump, bus.branch,
                              bus.memW, bus.weReg, bus.memToReg);

  assign mem_phase_s = (state_r == S_FETCH) || (state_r == S_MEM);
  assign wait_en_s   = mem_phase_s && !bus.mem_ready;
  // Any non-memory cycle clears, which covers every entry into FETCH or MEM
  assign wait_clr_s  = !mem_phase_s || bus.mem_ready;
  assign taken_s     = bus.ula_zero ^ ne_r;

  cont_espera #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_cont_espera (
    .clk    (clk),
    .rst    (rst),
    .clr    (wait_clr_s),
    .en     (wait_en_s),
    .expira (expira_s)
  );

  // Sequencer state, latched instruction class, status flags and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= S_FETCH;
      kind_r   <= K_NONE;
      ne_r     <= 1'b0;
      erro_r   <= 1'b0;
      halted_r <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_FETCH: begin
          if (bus.mem_ready) begin
            state_r <= S_DECODE;
          end else if (expira_s) begin
            erro_r   <= 1'b1;
            halted_r <= 1'b1;
            state_r  <= S_HALT;
          end
        end
        S_DECODE: begin
          kind_r  <= decoded_s;
          ne_r    <= (decoded_s == K_BRANCH) ? bus.notEqual : 1'b0;
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          case (kind_r)
            K_HLT: begin
              halted_r <= 1'b1;
              count_r  <= count_r + CNT_W'(1);
              state_r  <= S_HALT;
            end
            K_STORE, K_LOAD: state_r <= S_MEM;
            K_WB:            state_r <= S_WB;
            default: begin
              count_r <= count_r + CNT_W'(1);
              state_r <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (kind_r == K_LOAD) begin
              state_r <= S_WB;
            end else begin
              count_r <= count_r + CNT_W'(1);
              state_r <= S_FETCH;
            end
          end else if (expira_s) begin
            erro_r   <= 1'b1;
            halted_r <= 1'b1;
            state_r  <= S_HALT;
          end
        end
        S_WB: begin
          count_r <= count_r + CNT_W'(1);
          state_r <= S_FETCH;
        end
        S_HALT: begin
          // A timeout is sticky: only rst leaves HALT after erro
          if (bus.resume && !erro_r) begin
            halted_r <= 1'b0;
            state_r  <= S_FETCH;
          end
        end
        default: begin
          halted_r <= 1'b0;
          state_r  <= S_FETCH;
        end
      endcase
    end
  end

  // Single-cycle strobes decoded from the current state and this cycle's inputs
  always_comb begin
    mem_req_s = 1'b0;
    mem_sel_s = 1'b0;
    mem_we_s  = 1'b0;
    ir_we_s   = 1'b0;
    pc_we_s   = 1'b0;
    pc_src_s  = PC_SRC_INC;
    sjmp_we_s = 1'b0;
    mdr_we_s  = 1'b0;
    reg_we_s  = 1'b0;
    if (rst) begin
      mem_req_s = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req_s = 1'b1;
          if (bus.mem_ready) begin
            ir_we_s  = 1'b1;
            pc_we_s  = 1'b1;
            pc_src_s = PC_SRC_INC;
          end else begin
            ir_we_s = 1'b0;
          end
        end
        S_EXEC: begin
          case (kind_r)
            K_JUMP: begin
              pc_we_s  = 1'b1;
              pc_src_s = PC_SRC_JR;
            end
            K_SJMP: sjmp_we_s = 1'b1;
            K_BRANCH: begin
              if (taken_s) begin
                pc_we_s  = 1'b1;
                pc_src_s = PC_SRC_BR;
              end else begin
                pc_we_s = 1'b0;
              end
            end
            default: pc_we_s = 1'b0;
          endcase
        end
        S_MEM: begin
          mem_req_s = 1'b1;
          mem_sel_s = 1'b1;
          mem_we_s  = (kind_r == K_STORE);
          if (bus.mem_ready && (kind_r == K_LOAD)) begin
            mdr_we_s = 1'b1;
          end else begin
            mdr_we_s = 1'b0;
          end
        end
        S_WB:    reg_we_s  = 1'b1;
        default: mem_req_s = 1'b0;
      endcase
    end
  end

  assign bus.mem_req     = mem_req_s;
  assign bus.mem_sel     = mem_sel_s;
  assign bus.mem_we      = mem_we_s;
  assign bus.ir_we       = ir_we_s;
  assign bus.pc_we       = pc_we_s;
  assign bus.pc_src      = pc_src_s;
  assign bus.sjmp_we     = sjmp_we_s;
  assign bus.mdr_we      = mdr_we_s;
  assign bus.reg_we      = reg_we_s;
  assign bus.halted      = halted_r;
  assign bus.erro        = erro_r;
  assign bus.instr_count = count_r;

endmodule
